// File: rtl/adc_spi_frontend.sv
// SPI mode-0 ADC reader: periodic CS-framed conversion, box-car averaging of
// 2^AVG_LOG2 samples, and a held output value with a one-cycle valid strobe.
module adc_spi_frontend #(
    parameter int ADC_BITWIDTH  = 4,
    parameter int SPI_BITWIDTH  = 8,
    parameter int SCLK_DIV      = 4,
    parameter int AVG_LOG2      = 2,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    spi_miso_i,
    output logic                    spi_cs_n_o,
    output logic                    spi_sclk_o,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    ADC_valid_o,
    output logic                    busy_o
);

    localparam int ACC_W  = SPI_BITWIDTH + AVG_LOG2;
    localparam int PER_W  = $clog2(SAMPLE_PERIOD + 1);
    localparam int DIV_W  = $clog2(SCLK_DIV + 1);
    localparam int BIT_W  = $clog2(SPI_BITWIDTH + 1);
    localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    // Averaging shift and MSB-aligned truncation folded into a single shift.
    localparam int OUT_SHIFT = AVG_LOG2 + SPI_BITWIDTH - ADC_BITWIDTH;

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SPI_BITWIDTH - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CS_SETUP = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] CS_HOLD  = 3'd3;
    localparam logic [2:0] ACCUM    = 3'd4;

    logic                    miso_meta;
    logic                    miso_sync;
    logic [PER_W-1:0]        per_cnt;
    logic                    per_wrap;
    logic [2:0]              state;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [SPI_BITWIDTH-1:0] shreg;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        sum;
    logic [SCNT_W-1:0]       scnt;
    logic [ADC_BITWIDTH-1:0] avg_top;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= spi_miso_i;
            miso_sync <= miso_meta;
        end
    end

    assign per_wrap = (per_cnt == PER_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            per_cnt <= '0;
        end else if (clk_en_i) begin
            if (per_wrap) per_cnt <= '0;
            else          per_cnt <= per_cnt + PER_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            spi_cs_n_o <= 1'b1;
            spi_sclk_o <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else if (clk_en_i) begin
            case (state)
                IDLE: begin
                    if (per_wrap) begin
                        state      <= CS_SETUP;
                        spi_cs_n_o <= 1'b0;
                        div_cnt    <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sclk_o) begin
                            spi_sclk_o <= 1'b1;
                        end else begin
                            // Last high cycle: capture MISO right before the falling edge.
                            spi_sclk_o <= 1'b0;
                            shreg      <= (shreg << 1) | SPI_BITWIDTH'(miso_sync);
                            if (bit_cnt == BIT_LAST) state <= CS_HOLD;
                            else                     bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                CS_HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt    <= '0;
                        spi_cs_n_o <= 1'b1;
                        state      <= ACCUM;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ACCUM: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    spi_cs_n_o <= 1'b1;
                    spi_sclk_o <= 1'b0;
                    div_cnt    <= '0;
                end
            endcase
        end
    end

    assign sum     = acc + ACC_W'(shreg);
    assign avg_top = ADC_BITWIDTH'(sum >> OUT_SHIFT);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc         <= '0;
            scnt        <= '0;
            ADC_value_o <= '0;
            ADC_valid_o <= 1'b0;
        end else begin
            ADC_valid_o <= 1'b0;
            if (clk_en_i && state == ACCUM) begin
                if (scnt == SCNT_LAST) begin
                    ADC_value_o <= avg_top;
                    ADC_valid_o <= 1'b1;
                    acc         <= '0;
                    scnt        <= '0;
                end else begin
                    acc  <= sum;
                    scnt <= scnt + SCNT_W'(1);
                end
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_adc_spi_frontend.sv
// Bench for adc_spi_frontend: SPI ADC slave model, frame-timing checks and an
// averaging scoreboard; a second instance with a short period exercises trigger drops.
module tb_adc_spi_frontend;

    localparam int ADC_W = 4;
    localparam int SPI_W = 8;
    localparam int DIV   = 4;
    localparam int AVG   = 2;
    localparam int SP    = 100;
    localparam int SP2   = 50;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clk_en = 1'b1;
    logic miso = 1'b0;
    logic miso2 = 1'b0;

    logic             cs_n, sclk, valid, busy;
    logic [ADC_W-1:0] value;
    logic             cs_n2, sclk2, valid2, busy2;
    logic [ADC_W-1:0] value2;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned rel = 0;
    bit          init_done = 1'b0;
    bit          en_mode = 1'b0;

    int          vals[$];
    int          exp_q[$];
    int          grp_sum = 0;
    int          grp_n = 0;
    int          frames_done = 0;
    int          held = 0;

    adc_spi_frontend #(
        .ADC_BITWIDTH(ADC_W), .SPI_BITWIDTH(SPI_W), .SCLK_DIV(DIV),
        .AVG_LOG2(AVG), .SAMPLE_PERIOD(SP)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .spi_miso_i(miso),
        .spi_cs_n_o(cs_n), .spi_sclk_o(sclk), .ADC_value_o(value),
        .ADC_valid_o(valid), .busy_o(busy)
    );

    adc_spi_frontend #(
        .ADC_BITWIDTH(ADC_W), .SPI_BITWIDTH(SPI_W), .SCLK_DIV(DIV),
        .AVG_LOG2(AVG), .SAMPLE_PERIOD(SP2)
    ) dut2 (
        .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .spi_miso_i(miso2),
        .spi_cs_n_o(cs_n2), .spi_sclk_o(sclk2), .ADC_value_o(value2),
        .ADC_valid_o(valid2), .busy_o(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t = 0;
        while (frames_done < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        check("frames_completed", 32'(frames_done >= target), 1);
    endtask

    // clk_en driver: steady high, or toggling every clk when en_mode is set
    initial begin
        forever begin
            @(posedge clk);
            #2;
            clk_en = en_mode ? ~clk_en : 1'b1;
        end
    end

    // SPI slave model + frame timing + reference averaging (pushes expected values)
    initial begin
        logic        pcs = 1'b1;
        logic        psclk = 1'b0;
        logic [7:0]  sh = '0;
        int          cur = 0;
        int unsigned fstart = 0;
        int unsigned last_rise = 0;
        int          rises = 0;
        int          m;
        bit          in_frame = 1'b0;
        bit          first_after_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                grp_sum = 0;
                grp_n = 0;
                in_frame = 1'b0;
                first_after_rst = 1'b1;
                pcs = 1'b1;
                psclk = 1'b0;
                miso = 1'b0;
            end else begin
                m = en_mode ? 2 : 1;
                if (pcs && !cs_n) begin
                    in_frame = 1'b1;
                    fstart = cyc;
                    rises = 0;
                    cur = (vals.size() > 0) ? vals.pop_front() : int'($urandom_range(0, 255));
                    sh = 8'(cur);
                    miso = sh[7];
                    check("value_held_at_frame_start", 32'(value), held);
                    if (first_after_rst && !en_mode)
                        check("first_frame_offset", cyc - rel, SP);
                    first_after_rst = 1'b0;
                end
                if (in_frame && !psclk && sclk) begin
                    if (rises > 0) check("sclk_period", cyc - last_rise, 2 * DIV * m);
                    rises++;
                    last_rise = cyc;
                end
                if (in_frame && psclk && !sclk) begin
                    sh = sh << 1;
                    miso = sh[7];
                end
                if (in_frame && !pcs && cs_n) begin
                    check("sclk_rises", rises, SPI_W);
                    check("cs_low_cycles", cyc - fstart, 2 * DIV * (SPI_W + 1) * m);
                    grp_sum += cur;
                    grp_n++;
                    frames_done++;
                    if (grp_n == (1 << AVG)) begin
                        exp_q.push_back((grp_sum / (1 << AVG)) / (1 << (SPI_W - ADC_W)));
                        grp_sum = 0;
                        grp_n = 0;
                    end
                    in_frame = 1'b0;
                end
                pcs = cs_n;
                psclk = sclk;
            end
        end
    end

    // Output monitor: pops the scoreboard on every valid strobe
    initial begin
        logic pv = 1'b0;
        int   e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                held = 0;
                pv = 1'b0;
            end else begin
                if (valid) begin
                    check("valid_one_cycle", 32'(pv), 0);
                    check("valid_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("adc_value", 32'(value), e);
                        held = e;
                    end
                end
                pv = valid;
            end
        end
    end

    // Short-period instance: triggers during a frame are dropped
    initial begin
        logic        p2 = 1'b1;
        int unsigned starts[$];
        wait (init_done);
        while (cyc - rel < 260) begin
            @(negedge clk);
            if (p2 && !cs_n2) starts.push_back(cyc - rel);
            p2 = cs_n2;
            if (cyc - rel == 100 || cyc - rel == 200)
                check("dut2_busy_at_dropped_trigger", 32'(busy2), 1);
        end
        check("dut2_frame_count", starts.size(), 3);
        if (starts.size() == 3) begin
            check("dut2_start0", starts[0], 50);
            check("dut2_start1", starts[1], 150);
            check("dut2_start2", starts[2], 250);
        end
    end

    initial begin
        int f0;
        repeat (4) vals.push_back(8'hB7);
        vals.push_back(8'h10);
        vals.push_back(8'h20);
        vals.push_back(8'h30);
        vals.push_back(8'hA0);
        repeat (4) vals.push_back(int'($urandom_range(0, 255)));
        repeat (4) vals.push_back(8'hFF);
        repeat (4) vals.push_back(8'h00);

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cs_n", 32'(cs_n), 1);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_value", 32'(value), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        rel = cyc;
        init_done = 1'b1;

        wait_frames(4, 1500);
        repeat (3) @(posedge clk);
        #2;
        check("avg_b7", 32'(value), 4'hB);

        wait_frames(11, 1500);
        repeat (3) @(posedge clk);
        #2;
        check("avg_held_0x40", 32'(value), 4'h4);

        wait_frames(16, 1500);
        repeat (3) @(posedge clk);
        #2;
        check("avg_ff_no_wrap", 32'(value), 4'hF);

        wait_frames(20, 1500);
        repeat (3) @(posedge clk);
        #2;
        check("avg_zero", 32'(value), 4'h0);

        en_mode = 1'b1;
        wait_frames(28, 3000);
        repeat (4) @(posedge clk);
        #2;
        check("toggle_phase_drained", exp_q.size(), 0);
        en_mode = 1'b0;

        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
        rel = cyc;
        while (cyc < rel + 230) @(posedge clk);
        #2;
        check("mid_frame_busy", 32'(busy), 1);
        check("mid_frame_cs_low", 32'(cs_n), 0);
        rstn = 1'b0;
        #1;
        check("midrst_cs_n", 32'(cs_n), 1);
        check("midrst_sclk", 32'(sclk), 0);
        check("midrst_value", 32'(value), 0);
        check("midrst_busy", 32'(busy), 0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        rel = cyc;
        f0 = frames_done;
        wait_frames(f0 + 8, 1500);
        repeat (4) @(posedge clk);
        #2;
        check("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
